// File: rtl/tarsier_pyramid_pkg.sv
// Shared pyramid geometry: level defaults, index type and the per-level
// constant mapping functions used to convert level-grid coordinates to base grid.
package tarsier_pyramid_pkg;

  localparam int NUM_OCTAVES_DEF   = 4;
  localparam int NUM_SUBLEVELS_DEF = 2;
  localparam int NUM_REQ_DEF       = NUM_OCTAVES_DEF * NUM_SUBLEVELS_DEF;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] level_idx_t;

  function automatic int pow_int(input int b, input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * b;
    return p;
  endfunction

  function automatic int level_mult(input int o, input int s);
    return pow_int(2, o + 1) * pow_int(5, s);
  endfunction

  // The 4^s term is the round-to-nearest half-LSB at the final shift.
  function automatic int level_addend(input int o, input int s);
    return (pow_int(2, o) - 1) * pow_int(5, s) + pow_int(4, s);
  endfunction

  function automatic int level_shift(input int s);
    return 2 * s + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the pointer holds the last granted index and the search
// starts one past it; the pointer moves only when the caller asserts advance.
module rr_arbiter #(
  parameter int N = 8,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_grantIdx,
  output logic             o_any
);

  logic [IDX_W-1:0] r_ptr;

  always_comb begin : search
    logic found;
    int   idx;
    found      = 1'b0;
    idx        = 0;
    o_grant    = '0;
    o_grantIdx = r_ptr;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(r_ptr) + i) % N;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grantIdx   = IDX_W'(idx);
      end
    end
    o_any = found;
  end

  // Reset to the last index so requester 0 has first priority.
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= IDX_W'(N - 1);
    else if (i_advance) r_ptr <= o_grantIdx;
  end

endmodule

// File: rtl/pyramid_coord_scheduler.sv
// Shares one pyramid-to-base coordinate converter among all levels through a
// round-robin grant and a two-stage pipeline. Optional COORD_SCHED_SAT_EN saturates.
module pyramid_coord_scheduler
  import tarsier_pyramid_pkg::*;
#(
  parameter int COORD_BITS    = 16,
  parameter int NUM_OCTAVES   = NUM_OCTAVES_DEF,
  parameter int NUM_SUBLEVELS = NUM_SUBLEVELS_DEF,
  localparam int NUM_REQ      = NUM_OCTAVES * NUM_SUBLEVELS,
  localparam int LEVEL_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*COORD_BITS-1:0] req_x,
  input  logic [NUM_REQ*COORD_BITS-1:0] req_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COORD_BITS-1:0]         out_x,
  output logic [COORD_BITS-1:0]         out_y,
  output logic [LEVEL_W-1:0]            out_level,
  output logic                          out_clipped
);

  localparam int MULT_W  = $clog2(level_mult(NUM_OCTAVES - 1, NUM_SUBLEVELS - 1) + 1);
  localparam int PROD_W  = COORD_BITS + MULT_W + 1;
  localparam int SHIFT_W = $clog2(level_shift(NUM_SUBLEVELS - 1) + 1);

  logic [NUM_REQ-1:0]    w_grant;
  logic [LEVEL_W-1:0]    w_grantIdx;
  logic                  w_any, w_s1En, w_s2En, w_load;
  logic                  r_s1Valid;
  logic [LEVEL_W-1:0]    r_s1Level;
  logic [COORD_BITS-1:0] r_s1X, r_s1Y;
  logic [PROD_W-1:0]     w_mult, w_add, w_sumX, w_sumY;
  logic [SHIFT_W-1:0]    w_shift;
  logic [COORD_BITS-1:0] w_outX, w_outY;
  logic                  w_clip;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (req_valid),
    .i_advance  (w_any & w_load),
    .o_grant    (w_grant),
    .o_grantIdx (w_grantIdx),
    .o_any      (w_any)
  );

  assign w_s2En    = !out_valid | out_ready;
  assign w_s1En    = !r_s1Valid | w_s2En;
  assign w_load    = w_s1En & !rst;
  assign req_ready = w_grant & {NUM_REQ{w_load}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Level <= '0;
      r_s1X     <= '0;
      r_s1Y     <= '0;
    end else if (w_s1En) begin
      r_s1Valid <= w_any;
      r_s1Level <= w_grantIdx;
      r_s1X     <= req_x[w_grantIdx*COORD_BITS +: COORD_BITS];
      r_s1Y     <= req_y[w_grantIdx*COORD_BITS +: COORD_BITS];
    end
  end

  // Constants are elaborated per level; only the selected triple reaches the datapath.
  always_comb begin
    w_mult  = '0;
    w_add   = '0;
    w_shift = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (r_s1Level == LEVEL_W'(r)) begin
        w_mult  = PROD_W'(level_mult(r / NUM_SUBLEVELS, r % NUM_SUBLEVELS));
        w_add   = PROD_W'(level_addend(r / NUM_SUBLEVELS, r % NUM_SUBLEVELS));
        w_shift = SHIFT_W'(level_shift(r % NUM_SUBLEVELS));
      end
    end
    w_sumX = PROD_W'(r_s1X) * w_mult + w_add;
    w_sumY = PROD_W'(r_s1Y) * w_mult + w_add;
  end

`ifdef COORD_SCHED_SAT_EN
  logic [PROD_W-1:0] w_resX, w_resY;
  logic              w_ovfX, w_ovfY;

  always_comb begin
    w_resX = w_sumX >> w_shift;
    w_resY = w_sumY >> w_shift;
    w_ovfX = |w_resX[PROD_W-1:COORD_BITS];
    w_ovfY = |w_resY[PROD_W-1:COORD_BITS];
    w_outX = w_ovfX ? '1 : w_resX[COORD_BITS-1:0];
    w_outY = w_ovfY ? '1 : w_resY[COORD_BITS-1:0];
    w_clip = w_ovfX | w_ovfY;
  end
`else
  always_comb begin
    w_outX = COORD_BITS'(w_sumX >> w_shift);
    w_outY = COORD_BITS'(w_sumY >> w_shift);
    w_clip = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_level   <= '0;
      out_clipped <= 1'b0;
    end else if (w_s2En) begin
      out_valid   <= r_s1Valid;
      out_x       <= w_outX;
      out_y       <= w_outY;
      out_level   <= r_s1Level;
      out_clipped <= w_clip;
    end
  end

endmodule

// File: tb/tb_pyramid_coord_scheduler.sv
// Directed bench for pyramid_coord_scheduler: hand-computed single-level vectors
// plus a small arbiter/pipeline model with a scoreboard for bursts and stalls.
module tb_pyramid_coord_scheduler;

  localparam int CB = 16;
  localparam int NS = 2;
  localparam int NR = 8;
  localparam int LW = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [NR*CB-1:0] req_x, req_y;
  logic             out_valid, out_ready;
  logic [CB-1:0]    out_x, out_y;
  logic [LW-1:0]    out_level;
  logic             out_clipped;

  typedef struct {
    int lvl;
    int x;
    int y;
  } ent_t;

  int   total = 0;
  int   bad = 0;
  int   nAcc = 0;
  int   nOut = 0;
  int   mPtr = NR - 1;
  bit   mS1 = 1'b0;
  bit   mS2 = 1'b0;
  ent_t sb[$];

  always #5 clk = ~clk;

  pyramid_coord_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_level   (out_level),
    .out_clipped (out_clipped)
  );

  // Reference conversion straight from the level formula, truncated to CB bits.
  function automatic int conv(input int r, input int c);
    int     o, s, p5;
    longint v;
    o  = r / NS;
    s  = r % NS;
    p5 = 1;
    for (int i = 0; i < s; i++) p5 = p5 * 5;
    v = (longint'(c) * (longint'(1) << (o + 1)) * p5 + ((1 << o) - 1) * p5 + (1 << (2 * s))) >> (2 * s + 1);
    return int'(v & 64'hFFFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Single isolated transfer; expects the result exactly two cycles later.
  task automatic applyStimulus(input int r, input int x, input int y,
                               input int expX, input int expY, input bit expClip);
    req_valid = '0;
    req_valid[r] = 1'b1;
    req_x = '0;
    req_y = '0;
    req_x[r*CB +: CB] = CB'(x);
    req_y[r*CB +: CB] = CB'(y);
    #1;
    checkOutput("single_ready", req_ready, NR'(1) << r);
    @(posedge clk); #1;
    req_valid = '0;
    checkOutput("single_lat1_valid", out_valid, 0);
    @(posedge clk); #1;
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_x", out_x, expX);
    checkOutput("single_y", out_y, expY);
    checkOutput("single_level", out_level, r);
    checkOutput("single_clip", out_clipped, expClip);
    @(posedge clk); #1;
    checkOutput("single_drain", out_valid, 0);
    mPtr = r;
  endtask

  // One clock of model-checked operation; inputs must already be driven.
  task automatic stepCycle();
    logic [NR-1:0] expRdy;
    bit            s1en, s2en, any;
    int            nxt, idx;
    ent_t          e;
    #1;
    s2en = !mS2 || out_ready;
    s1en = !mS1 || s2en;
    any  = 1'b0;
    nxt  = 0;
    for (int i = 1; i <= NR; i++) begin
      idx = (mPtr + i) % NR;
      if (!any && req_valid[idx]) begin
        any = 1'b1;
        nxt = idx;
      end
    end
    expRdy = (s1en && any) ? (NR'(1) << nxt) : '0;
    checkOutput("rr_ready", req_ready, expRdy);
    checkOutput("rr_out_valid", out_valid, mS2);
    if (mS2 && sb.size() > 0) begin
      checkOutput("rr_level", out_level, sb[0].lvl);
      checkOutput("rr_x", out_x, sb[0].x);
      checkOutput("rr_y", out_y, sb[0].y);
    end
    if (mS2 && out_ready) begin
      void'(sb.pop_front());
      nOut++;
    end
    if (s2en) mS2 = mS1;
    if (s1en) mS1 = any;
    if (s1en && any) begin
      e.lvl = nxt;
      e.x   = conv(nxt, int'(req_x[nxt*CB +: CB]));
      e.y   = conv(nxt, int'(req_y[nxt*CB +: CB]));
      sb.push_back(e);
      mPtr = nxt;
      nAcc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic driveAll();
    for (int r = 0; r < NR; r++) begin
      req_x[r*CB +: CB] = CB'(r * 100 + 5);
      req_y[r*CB +: CB] = CB'(r * 3 + 1);
    end
    req_valid = '1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '1;
    req_x = '0;
    req_y = '0;
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset_ready", req_ready, 0);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_x", out_x, 0);
    checkOutput("reset_y", out_y, 0);
    checkOutput("reset_level", out_level, 0);
    checkOutput("reset_clip", out_clipped, 0);
    rst = 1'b0;
    req_valid = '0;
    stepCycle();

    applyStimulus(0, 123, 7, 123, 7, 1'b0);
    applyStimulus(2, 10, 3, 21, 7, 1'b0);
    applyStimulus(3, 7, 7, 18, 18, 1'b0);
    applyStimulus(1, 8, 8, 10, 10, 1'b0);
`ifdef COORD_SCHED_SAT_EN
    applyStimulus(6, 10000, 1, 65535, 12, 1'b1);
`else
    applyStimulus(6, 10000, 1, 14468, 12, 1'b0);
`endif

    driveAll();
    for (int i = 0; i < 12; i++) stepCycle();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) stepCycle();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) stepCycle();
    req_valid = '0;
    for (int i = 0; i < 6 && sb.size() > 0; i++) stepCycle();
    checkOutput("burst_drained", sb.size(), 0);
    checkOutput("burst_no_loss", nOut, nAcc);

    driveAll();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_ready", req_ready, 0);
    rst = 1'b0;
    sb.delete();
    mS1 = 1'b0;
    mS2 = 1'b0;
    mPtr = NR - 1;
    nAcc = 0;
    nOut = 0;
    out_ready = 1'b1;
    #1;
    checkOutput("post_rst_grant", req_ready, 8'h01);
    for (int i = 0; i < 10; i++) stepCycle();
    req_valid = '0;
    for (int i = 0; i < 6 && sb.size() > 0; i++) stepCycle();
    checkOutput("post_rst_drained", sb.size(), 0);
    checkOutput("post_rst_no_loss", nOut, nAcc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
